// File: rtl/reorder_buffer.sv
// In-order retire ROB: dual alloc/complete, up to 2 commits per edge, frees registered one cycle after commit.
// Allocation needs 2 free entries (no same-cycle commit bypass); optional commit counter under ROB_STATS_EN.
module reorder_buffer #(
  parameter int NUM_ROB_ENTRIES = 16,
  parameter int NUM_P_REGS      = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc0_en_i,
  input  logic                          alloc1_en_i,
  input  logic                          alloc_wr0_i,
  input  logic                          alloc_wr1_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] alloc_old_pdest0_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] alloc_old_pdest1_i,
  output logic                          alloc_ready_o,
  output logic [$clog2(NUM_ROB_ENTRIES)-1:0] alloc_idx0_o,
  output logic [$clog2(NUM_ROB_ENTRIES)-1:0] alloc_idx1_o,
  input  logic                          complete0_en_i,
  input  logic                          complete1_en_i,
  input  logic [$clog2(NUM_ROB_ENTRIES)-1:0] complete0_idx_i,
  input  logic [$clog2(NUM_ROB_ENTRIES)-1:0] complete1_idx_i,
  output logic                          en_free_reg0_o,
  output logic                          en_free_reg1_o,
  output logic [$clog2(NUM_P_REGS)-1:0] free_reg0_o,
  output logic [$clog2(NUM_P_REGS)-1:0] free_reg1_o,
  output logic                          empty_o,
  output logic                          full_o
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                   commit_count_o
`endif
);

  localparam int IW = $clog2(NUM_ROB_ENTRIES);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int CW = IW + 1;

  logic [IW-1:0]          head_q, head_d, tail_q, tail_d, head1;
  logic [CW-1:0]          count_q, count_d;
  logic [NUM_ROB_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, wr_q, wr_d;
  logic [PW-1:0]          old_pdest_q [NUM_ROB_ENTRIES];
  logic [PW-1:0]          old_pdest_d [NUM_ROB_ENTRIES];
  logic                   en_free0_q, en_free0_d, en_free1_q, en_free1_d;
  logic [PW-1:0]          free_reg0_q, free_reg0_d, free_reg1_q, free_reg1_d;
  logic                   retire0, retire1, do_alloc0, do_alloc1;
  logic [1:0]             n_alloc, n_commit;

  assign alloc_ready_o  = (count_q <= CW'(NUM_ROB_ENTRIES - 2));
  assign alloc_idx0_o   = tail_q;
  assign alloc_idx1_o   = tail_q + IW'(alloc0_en_i);
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == CW'(NUM_ROB_ENTRIES));
  assign en_free_reg0_o = en_free0_q;
  assign en_free_reg1_o = en_free1_q;
  assign free_reg0_o    = free_reg0_q;
  assign free_reg1_o    = free_reg1_q;

  // Retirement looks only at start-of-cycle done bits, so a same-edge completion waits one edge.
  assign head1     = head_q + 1'b1;
  assign retire0   = valid_q[head_q] & done_q[head_q];
  assign retire1   = retire0 & valid_q[head1] & done_q[head1];
  assign do_alloc0 = alloc_ready_o & alloc0_en_i;
  assign do_alloc1 = alloc_ready_o & alloc1_en_i;
  assign n_alloc   = {1'b0, do_alloc0} + {1'b0, do_alloc1};
  assign n_commit  = {1'b0, retire0} + {1'b0, retire1};

  always_comb begin
    valid_d     = valid_q;
    done_d      = done_q;
    wr_d        = wr_q;
    old_pdest_d = old_pdest_q;
    if (complete0_en_i && valid_q[complete0_idx_i]) done_d[complete0_idx_i] = 1'b1;
    if (complete1_en_i && valid_q[complete1_idx_i]) done_d[complete1_idx_i] = 1'b1;
    if (retire0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (retire1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end
    if (do_alloc0) begin
      valid_d[tail_q]     = 1'b1;
      done_d[tail_q]      = 1'b0;
      wr_d[tail_q]        = alloc_wr0_i;
      old_pdest_d[tail_q] = alloc_old_pdest0_i;
    end
    if (do_alloc1) begin
      valid_d[alloc_idx1_o]     = 1'b1;
      done_d[alloc_idx1_o]      = 1'b0;
      wr_d[alloc_idx1_o]        = alloc_wr1_i;
      old_pdest_d[alloc_idx1_o] = alloc_old_pdest1_i;
    end
    head_d      = head_q + IW'(n_commit);
    tail_d      = tail_q + IW'(n_alloc);
    count_d     = count_q + CW'(n_alloc) - CW'(n_commit);
    en_free0_d  = retire0 & wr_q[head_q];
    en_free1_d  = retire1 & wr_q[head1];
    free_reg0_d = en_free0_d ? old_pdest_q[head_q] : '0;
    free_reg1_d = en_free1_d ? old_pdest_q[head1] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      wr_q        <= '0;
      old_pdest_q <= '{default: '0};
      en_free0_q  <= 1'b0;
      en_free1_q  <= 1'b0;
      free_reg0_q <= '0;
      free_reg1_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      wr_q        <= wr_d;
      old_pdest_q <= old_pdest_d;
      en_free0_q  <= en_free0_d;
      en_free1_q  <= en_free1_d;
      free_reg0_q <= free_reg0_d;
      free_reg1_q <= free_reg1_d;
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] commit_count_q, commit_count_d;

  assign commit_count_d = commit_count_q + 32'(n_commit);
  assign commit_count_o = commit_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) commit_count_q <= '0;
    else       commit_count_q <= commit_count_d;
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized + directed bench for reorder_buffer; queue-based ROB model feeds a free-strobe scoreboard.
module tb_reorder_buffer;
  localparam int N = 16;
  localparam int P = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       a0, a1, w0, w1;
  logic [5:0] p0, p1;
  logic       ready;
  logic [3:0] idx0, idx1;
  logic       c0, c1;
  logic [3:0] ci0, ci1;
  logic       ef0, ef1;
  logic [5:0] fr0, fr1;
  logic       empty, full;
`ifdef ROB_STATS_EN
  logic [31:0] commit_count;
`endif

  always #5 clk = ~clk;

  reorder_buffer #(.NUM_ROB_ENTRIES(N), .NUM_P_REGS(P)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc0_en_i(a0), .alloc1_en_i(a1), .alloc_wr0_i(w0), .alloc_wr1_i(w1),
    .alloc_old_pdest0_i(p0), .alloc_old_pdest1_i(p1),
    .alloc_ready_o(ready), .alloc_idx0_o(idx0), .alloc_idx1_o(idx1),
    .complete0_en_i(c0), .complete1_en_i(c1),
    .complete0_idx_i(ci0), .complete1_idx_i(ci1),
    .en_free_reg0_o(ef0), .en_free_reg1_o(ef1),
    .free_reg0_o(fr0), .free_reg1_o(fr1),
    .empty_o(empty), .full_o(full)
`ifdef ROB_STATS_EN
    , .commit_count_o(commit_count)
`endif
  );

  typedef struct { int idx; bit wr; int pd; bit done; } ent_t;
  typedef struct { int cyc; int port; int pd; } fr_t;

  ent_t q[$];
  fr_t  exq[$];
  int   tail_m = 0;
  int   stat_m = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int port, input int val);
    fr_t e;
    if (exq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_free port=%0d actual=%0d expected=none (cycle %0d)", port, val, cyc);
    end else begin
      e = exq.pop_front();
      chk("free_cycle", cyc, e.cyc);
      chk("free_port", port, e.port);
      chk("free_reg", val, e.pd);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected free.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ef0 === 1'b1) pop_chk(0, int'(fr0));
      else chk("free0_zero_when_idle", int'(fr0), 0);
      if (ef1 === 1'b1) pop_chk(1, int'(fr1));
      else chk("free1_zero_when_idle", int'(fr1), 0);
    end
  end

  task automatic step(input bit r, input bit ia0, input bit ia1, input bit iw0, input bit iw1,
                      input int ip0, input int ip1, input bit ic0, input bit ic1,
                      input int ici0, input int ici1);
    int  n;
    int  sz;
    bit  rdy;
    @(negedge clk);
    rst = r; a0 = ia0; a1 = ia1; w0 = iw0; w1 = iw1;
    p0 = 6'(ip0); p1 = 6'(ip1); c0 = ic0; c1 = ic1; ci0 = 4'(ici0); ci1 = 4'(ici1);
    #1;
    sz  = q.size();
    rdy = (sz <= N - 2);
    if (mon_on) begin
      chk("empty", int'(empty), int'(sz == 0));
      chk("full", int'(full), int'(sz == N));
      chk("alloc_ready", int'(ready), int'(rdy));
      chk("alloc_idx0", int'(idx0), tail_m);
      chk("alloc_idx1", int'(idx1), (tail_m + int'(ia0)) % N);
`ifdef ROB_STATS_EN
      chk("commit_count", int'(commit_count), stat_m);
`endif
    end
    if (r) begin
      q.delete();
      tail_m = 0;
      stat_m = 0;
    end else begin
      n = 0;
      if (sz > 0 && q[0].done) n = 1;
      if (n == 1 && sz > 1 && q[1].done) n = 2;
      for (int k = 0; k < n; k++)
        if (q[k].wr) exq.push_back('{cyc: cyc + 1, port: k, pd: q[k].pd});
      for (int k = 0; k < sz; k++) begin
        if (ic0 && q[k].idx == ici0) q[k].done = 1'b1;
        if (ic1 && q[k].idx == ici1) q[k].done = 1'b1;
      end
      for (int k = 0; k < n; k++) void'(q.pop_front());
      stat_m += n;
      if (rdy && ia0) begin
        q.push_back('{idx: tail_m, wr: iw0, pd: ip0, done: 1'b0});
        tail_m = (tail_m + 1) % N;
      end
      if (rdy && ia1) begin
        q.push_back('{idx: tail_m, wr: iw1, pd: ip1, done: 1'b0});
        tail_m = (tail_m + 1) % N;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();                      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_rst();                    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alloc(input bit x0, input bit x1, input bit y0, input bit y1, input int d0, input int d1);
    step(0, x0, x1, y0, y1, d0, d1, 0, 0, 0, 0);
  endtask
  task automatic comp(input bit x0, input bit x1, input int i0, input int i1);
    step(0, 0, 0, 0, 0, 0, 0, x0, x1, i0, i1);
  endtask

  initial begin
    int t;
    int ia, ib;
    int pick;
    rst = 1'b1; a0 = 0; a1 = 0; w0 = 0; w1 = 0; p0 = '0; p1 = '0;
    c0 = 0; c1 = 0; ci0 = '0; ci1 = '0;

    // Reset values and the two-wide commit with paired frees.
    do_rst();
    mon_on = 1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_idx0", int'(idx0), 0);
    alloc(1, 1, 1, 1, 33, 34);
    comp(1, 0, 1, 0);
    idle();
    comp(1, 0, 0, 0);
    idle();
    idle();
    idle();

    // Non-writing instruction retires silently.
    t = tail_m;
    alloc(1, 0, 0, 0, 5, 0);
    comp(1, 0, t, 0);
    idle();
    idle();
    #1;
    chk("wr0_empty", int'(empty), 1);
`ifdef ROB_STATS_EN
    chk("stats_after_three", int'(commit_count), 3);
`endif

    // Fill to full, then an extra request must be dropped.
    do_rst();
    for (int i = 0; i < 8; i++) alloc(1, 1, 1, 1, i, i + 8);
    alloc(1, 1, 1, 1, 60, 61);
    idle();
    #1;
    chk("fill_full", int'(full), 1);
    chk("fill_not_ready", int'(ready), 0);
    chk("fill_idx_wrapped", int'(idx0), 0);

    // Forty back-to-back pairs: indices wrap, frees follow allocation order.
    do_rst();
    for (int i = 0; i < 40; i++) begin
      ia = tail_m;
      ib = (tail_m + 1) % N;
      alloc(1, 1, 1, 1, i % P, (i + 20) % P);
      comp(1, 1, ia, ib);
    end
    idle();
    idle();
    idle();
    #1;
    chk("wrap_empty", int'(empty), 1);

    // Reset with completed-but-blocked entries discards them without frees.
    do_rst();
    for (int i = 0; i < 3; i++) alloc(1, 1, 1, 1, 40 + i, 50 + i);
    comp(1, 1, 1, 2);
    comp(1, 1, 3, 4);
    comp(1, 1, 5, 5);
    do_rst();
    idle();
    #1;
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_idx0", int'(idx0), 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else begin
        ia = q.size() > 0 ? q[$urandom_range(0, q.size() - 1)].idx : 0;
        ib = q.size() > 0 ? q[$urandom_range(0, q.size() - 1)].idx : 0;
        pick = $urandom_range(0, 3);
        if (pick == 0) ia = $urandom_range(0, N - 1);
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, P - 1), $urandom_range(0, P - 1),
             1'($urandom), 1'($urandom), ia, ib);
      end
    end

    // Drain: complete everything still in flight.
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      if (q.size() > 1) comp(1, 1, q[0].idx, q[1].idx);
      else comp(1, 0, q[0].idx, 0);
    end
    idle();
    idle();
    idle();
    #1;
    chk("drain_model_empty", q.size(), 0);
    chk("drain_empty", int'(empty), 1);
    chk("scoreboard_left", exq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
